// File: rtl/key_scan_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_scan_debounce
// Description : Multi-channel push-button conditioner. Each raw key pin is
//               synchronised, debounced with a tick-enabled sampler, and
//               turned into a clean level, press/release pulses, a
//               long-press flag and an auto-repeat pulse train.
// Revision    : 1.0 - initial release
// ============================================================================
module key_scan_debounce #(
  parameter int NUM_KEYS       = 4,
  parameter int DIV_WIDTH      = 16,
  parameter int STABLE_SAMPLES = 3,
  parameter int ACTIVE_LOW     = 1,
  parameter int HOLD_TICKS     = 64,
  parameter int REPEAT_TICKS   = 16
) (
  input  logic                BJ_CLK,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] KEY_IN,
  output logic [NUM_KEYS-1:0] KEY_LEVEL,
  output logic [NUM_KEYS-1:0] KEY_PRESS,
  output logic [NUM_KEYS-1:0] KEY_RELEASE,
  output logic [NUM_KEYS-1:0] KEY_HOLD,
  output logic [NUM_KEYS-1:0] KEY_REPEAT,
  output logic                TICK
);

  localparam int c_stb_w  = $clog2(STABLE_SAMPLES + 1);
  localparam int c_hold_w = $clog2(HOLD_TICKS + 1);
  localparam int c_rep_w  = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;

  // Pin level of a released key.
  localparam logic c_idle = (ACTIVE_LOW != 0);

  localparam logic [c_stb_w-1:0]  c_stb_last  = c_stb_w'(STABLE_SAMPLES - 1);
  localparam logic [c_hold_w-1:0] c_hold_max  = c_hold_w'(HOLD_TICKS);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_TICKS - 1);

  logic [DIV_WIDTH-1:0] r_div;
  logic                 w_tick;
  logic [NUM_KEYS-1:0]  r_sync1;
  logic [NUM_KEYS-1:0]  r_sync2;

  // Free-running prescaler; wraps from all-ones to zero.
  always_ff @(posedge BJ_CLK or posedge RESET) begin
    if (RESET) r_div <= '0;
    else       r_div <= r_div + 1'b1;
  end

  assign w_tick = &r_div;
  assign TICK   = w_tick;

  // Two-flop synchroniser, held at the idle pin level in reset.
  always_ff @(posedge BJ_CLK or posedge RESET) begin
    if (RESET) begin
      r_sync1 <= {NUM_KEYS{c_idle}};
      r_sync2 <= {NUM_KEYS{c_idle}};
    end else begin
      r_sync1 <= KEY_IN;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic [c_stb_w-1:0]  r_mis;
    logic                r_level;
    logic [c_hold_w-1:0] r_hold;
    logic                r_press;
    logic                r_release;
    logic                w_accept;
    logic                w_level_nxt;
    logic                w_pressed;
    logic                w_pressed_nxt;
    logic                w_held;
    logic                w_hold_step;

    // Acceptance of a new level and the pressed state before/after this edge.
    // Hold/repeat logic looks at the next level so that everything drops in
    // the same cycle the release pulse appears.
    always_comb begin
      w_accept      = w_tick && (r_sync2[i] != r_level) && (r_mis == c_stb_last);
      w_level_nxt   = r_level ^ w_accept;
      w_pressed     = (r_level != c_idle);
      w_pressed_nxt = (w_level_nxt != c_idle);
      w_held        = (r_hold == c_hold_max);
      w_hold_step   = w_tick && w_pressed && w_pressed_nxt && !w_held;
    end

    // Debounce: a disagreeing sample must persist STABLE_SAMPLES ticks.
    always_ff @(posedge BJ_CLK or posedge RESET) begin
      if (RESET) begin
        r_mis   <= '0;
        r_level <= c_idle;
      end else if (w_tick) begin
        if ((r_sync2[i] == r_level) || w_accept) r_mis <= '0;
        else                                     r_mis <= r_mis + 1'b1;
        r_level <= w_level_nxt;
      end
    end

    // Registered edge pulses, visible together with the new level.
    always_ff @(posedge BJ_CLK or posedge RESET) begin
      if (RESET) begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_accept && w_pressed_nxt;
        r_release <= w_accept && !w_pressed_nxt;
      end
    end

    // Hold counter: counts ticks after the press tick, saturating.
    always_ff @(posedge BJ_CLK or posedge RESET) begin
      if (RESET)              r_hold <= '0;
      else if (!w_pressed_nxt) r_hold <= '0;
      else if (w_hold_step)   r_hold <= r_hold + 1'b1;
    end

    if (REPEAT_TICKS > 0) begin : g_rep_on
      localparam logic [c_rep_w-1:0] c_rep_last = c_rep_w'(REPEAT_TICKS - 1);
      logic [c_rep_w-1:0] r_rep_cnt;
      logic               r_repeat;
      logic               w_hold_first;
      logic               w_rep_tick;
      logic               w_pulse;

      // First pulse rides on the hold rising edge, then every REPEAT_TICKS.
      always_comb begin
        w_hold_first = w_hold_step && (r_hold == c_hold_last);
        w_rep_tick   = w_tick && w_held && w_pressed_nxt;
        w_pulse      = w_hold_first || (w_rep_tick && (r_rep_cnt == c_rep_last));
      end

      // Repeat interval counter, restarting on every pulse.
      always_ff @(posedge BJ_CLK or posedge RESET) begin
        if (RESET) begin
          r_rep_cnt <= '0;
          r_repeat  <= 1'b0;
        end else begin
          r_repeat <= w_pulse;
          if (!w_pressed_nxt || w_pulse) r_rep_cnt <= '0;
          else if (w_rep_tick)           r_rep_cnt <= r_rep_cnt + 1'b1;
        end
      end

      assign KEY_REPEAT[i] = r_repeat;
    end else begin : g_rep_off
      assign KEY_REPEAT[i] = 1'b0;
    end

    assign KEY_LEVEL[i]   = r_level;
    assign KEY_PRESS[i]   = r_press;
    assign KEY_RELEASE[i] = r_release;
    assign KEY_HOLD[i]    = w_held;
  end

endmodule
`default_nettype wire
